// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder: access sizes,
// response-slot states, store strobe generation and load-data alignment.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} rsp_state_e;

  function automatic logic [3:0] strobe_gen(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << lane;
      SZ_HALF: s = 4'b0011 << lane;
      SZ_WORD: s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] wdata_gen(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Right-align the addressed bytes and zero-fill above the access size.
  function automatic logic [31:0] lane_align(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: r = {24'h0, sh[7:0]};
      SZ_HALF: r = {16'h0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port data SRAM: byte-enabled synchronous write, registered read.
module dmem_sram #(
  parameter int DEPTH_WORDS = 4096,
  localparam int IDXW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic            re_i,
  input  logic [IDXW-1:0] addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
    // rdata holds between reads so a stalled response stays stable.
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store slave for the memory stage: one-deep response slot with
// pass-through on consume, alignment/range checking, 1-cycle load latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDXW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  rsp_state_e  state_q, state_d;
  logic        err_q, err_d;
  logic        ld_q, ld_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;

  logic        accept;
  logic        req_err;
  logic [31:0] off;
  logic [1:0]  lane;
  logic [31:0] sram_rdata;
  logic        unused_off;

  assign rsp_valid = (state_q == S_FULL);
  assign req_ready = !rsp_valid || rsp_ready;
  // A request presented alongside rst must not touch the SRAM.
  assign accept    = req_valid && req_ready && !rst;

  assign off  = req_addr - BASE_ADDR;
  assign lane = req_addr[1:0];
  assign unused_off = ^{off[31:IDXW+2], off[1:0]};

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3)                              req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])            req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (off >= SPAN)                                   req_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ld_d    = ld_q;
    lane_d  = lane_q;
    size_d  = size_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (accept) state_d = S_FULL;
               else if (rsp_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (accept) begin
      err_d  = req_err;
      ld_d   = !req_we && !req_err;
      lane_d = lane;
      size_d = req_size;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
    end
  end

  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk     (clk),
    .we_i    (accept && req_we && !req_err),
    .be_i    (strobe_gen(req_size, lane)),
    .re_i    (accept && !req_we && !req_err),
    .addr_i  (off[IDXW+1:2]),
    .wdata_i (wdata_gen(req_size, req_wdata)),
    .rdata_o (sram_rdata)
  );

  // Stores and errored requests report zero data.
  assign rsp_rdata = ld_q ? lane_align(sram_rdata, lane_q, size_q) : 32'h0;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: lanes, errors, backpressure, reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h8000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic present(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_size  = sz;
    req_wdata = wd;
  endtask

  // One request accepted on the next edge; the response is checked 1ns later.
  task automatic do_req(input string tag, input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
    present(we, a, sz, wd);
    rsp_ready = 1'b1;
    #1;
    chk({tag, ".ready"}, {31'h0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".valid"}, {31'h0, rsp_valid}, 32'd1);
    chk({tag, ".rdata"}, rsp_rdata, exp_d);
    chk({tag, ".err"},   {31'h0, rsp_err}, {31'h0, exp_e});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = 2'd0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.err",   {31'h0, rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready", {31'h0, req_ready}, 32'd1);

    do_req("st_w",   1'b1, 32'h8000_0010, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_req("ld_w",   1'b0, 32'h8000_0010, 2'd2, 32'h0, 32'hDEAD_BEEF, 1'b0);
    do_req("st_b",   1'b1, 32'h8000_0013, 2'd0, 32'hFFFF_FF12, 32'h0, 1'b0);
    do_req("st_h",   1'b1, 32'h8000_0010, 2'd1, 32'hAAAA_5678, 32'h0, 1'b0);
    do_req("ld_w2",  1'b0, 32'h8000_0010, 2'd2, 32'h0, 32'h12AD_5678, 1'b0);
    do_req("ld_b",   1'b0, 32'h8000_0013, 2'd0, 32'h0, 32'h0000_0012, 1'b0);
    do_req("ld_h",   1'b0, 32'h8000_0012, 2'd1, 32'h0, 32'h0000_12AD, 1'b0);
    do_req("ld_b1",  1'b0, 32'h8000_0011, 2'd0, 32'h0, 32'h0000_0056, 1'b0);

    do_req("e_half", 1'b0, 32'h8000_0011, 2'd1, 32'h0, 32'h0, 1'b1);
    do_req("e_word", 1'b0, 32'h8000_0012, 2'd2, 32'h0, 32'h0, 1'b1);
    do_req("st_w0",  1'b1, 32'h8000_0000, 2'd2, 32'h1122_3344, 32'h0, 1'b0);
    do_req("e_rng",  1'b1, 32'h8000_4000, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req("e_wrap", 1'b1, 32'h7FFF_FFFC, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req("ld_w0",  1'b0, 32'h8000_0000, 2'd2, 32'h0, 32'h1122_3344, 1'b0);
    do_req("e_sz3",  1'b0, 32'h8000_0000, 2'd3, 32'h0, 32'h0, 1'b1);
    do_req("ld_top", 1'b0, 32'h8000_3FFC, 2'd0, 32'h0, 32'h0, 1'b0);

    // Backpressure: slot holds a load response while a store waits.
    do_req("st_20",  1'b1, 32'h8000_0020, 2'd2, 32'h0BAD_F00D, 32'h0, 1'b0);
    do_req("ld_bp",  1'b0, 32'h8000_0010, 2'd2, 32'h0, 32'h12AD_5678, 1'b0);
    rsp_ready = 1'b0;
    present(1'b1, 32'h8000_0020, 2'd2, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.ready", {31'h0, req_ready}, 32'd0);
      chk("bp.valid", {31'h0, rsp_valid}, 32'd1);
      chk("bp.rdata", rsp_rdata, 32'h12AD_5678);
      chk("bp.err",   {31'h0, rsp_err}, 32'd0);
      @(posedge clk);
    end
    #1;
    do_req("bp.st",  1'b1, 32'h8000_0020, 2'd2, 32'hCAFE_F00D, 32'h0, 1'b0);
    do_req("bp.ld",  1'b0, 32'h8000_0020, 2'd2, 32'h0, 32'hCAFE_F00D, 1'b0);
    do_req("bp.ld2", 1'b0, 32'h8000_0010, 2'd2, 32'h0, 32'h12AD_5678, 1'b0);

    // Back-to-back store/load to one word, one request per cycle.
    do_req("bb.s0", 1'b1, 32'h8000_0030, 2'd2, 32'h0000_0001, 32'h0, 1'b0);
    do_req("bb.l0", 1'b0, 32'h8000_0030, 2'd2, 32'h0, 32'h0000_0001, 1'b0);
    do_req("bb.s1", 1'b1, 32'h8000_0031, 2'd0, 32'h0000_00A5, 32'h0, 1'b0);
    do_req("bb.l1", 1'b0, 32'h8000_0030, 2'd2, 32'h0, 32'h0000_A501, 1'b0);
    do_req("bb.s2", 1'b1, 32'h8000_0032, 2'd1, 32'h0000_BEEF, 32'h0, 1'b0);
    do_req("bb.l2", 1'b0, 32'h8000_0030, 2'd2, 32'h0, 32'hBEEF_A501, 1'b0);

    // Reset while FULL with a store presented: response dropped, no commit.
    present(1'b1, 32'h8000_0030, 2'd2, 32'hFFFF_0000);
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr.valid", {31'h0, rsp_valid}, 32'd0);
    chk("mr.rdata", rsp_rdata, 32'd0);
    chk("mr.err",   {31'h0, rsp_err}, 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("mr.ready", {31'h0, req_ready}, 32'd1);
    do_req("mr.ld", 1'b0, 32'h8000_0030, 2'd2, 32'h0, 32'hBEEF_A501, 1'b0);

    // Drain: slot empties when consumed without a new request.
    @(posedge clk); #1;
    chk("drain.valid", {31'h0, rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that serves load/store requests from the CPU memory stage. It accepts one request per cycle over a valid/ready channel, performs byte/half/word writes with per-lane strobes, and returns right-aligned read data with a 1-cycle latency. Responses go over a valid/ready channel that supports backpressure. The block sits between the memory stage and the on-chip data SRAM, and replaces the behavioural read/write calls with a synthesizable, cycle-accurate slave.

## Interface
- DEPTH_WORDS, 4096: SRAM depth in 32-bit words; must be a power of 2.
- BASE_ADDR, 32'h8000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_wdata  in  32  store data, taken from the low bits (rs2 as-is).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data, right-aligned and zero-filled above the size; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range, or had an illegal size.

## Operation
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - A response is consumed when rsp_valid && rsp_ready.
  - req_ready = !rsp_valid || rsp_ready. This is a one-deep response slot with pass-through on consume.
- State: EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on a simultaneous consume and accept.
  - FULL -> EMPTY on consume with no accept.
  - FULL with no consume holds every rsp_* output stable.
- Error check, evaluated on accept:
  - size 3 is an error.
  - half with addr[0] = 1 is an error.
  - word with addr[1:0] != 0 is an error.
  - addr outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) is an error.
  - On error: no SRAM write; response has rsp_err = 1 and rsp_rdata = 0.
- Index: word index = (addr - BASE_ADDR) >> 2; lane = addr[1:0].
- Store write strobes and data:
  - byte: strobe 1 << lane; data = wdata[7:0] replicated to 4 lanes.
  - half: strobe 0011 << lane; data = wdata[15:0] replicated.
  - word: strobe 1111; data = wdata.
  - A store produces a response with rsp_rdata = 0 and rsp_err = 0.
- Load: the SRAM word is read at accept and shifted right by lane*8.
  - byte keeps [7:0]; half keeps [15:0]; the rest is zero.
  - Sign extension stays in the requester.
- Reset: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state EMPTY. req_ready = 1 in the cycle after rst deasserts. SRAM contents are not cleared.

## Timing
- Accept at edge N, so the store commits to the SRAM at edge N and rsp_valid is 1 after edge N. Load latency is 1 cycle.
- A load accepted at edge N+1 to the same word as a store accepted at edge N returns the new data. No forwarding is needed, because the write commits first.
- Throughput is 1 request/cycle while rsp_ready is held at 1.
- When rsp_ready = 0 and FULL, req_ready = 0, and no SRAM access of any kind occurs.
- rst asserted mid-transaction:
  - the pending response is dropped and rsp_valid = 0 after the edge;
  - a store presented in the same cycle as rst is not committed.
- Address arithmetic is 32-bit unsigned. The range check compares addr - BASE_ADDR < 4*DEPTH_WORDS, so a wrap below BASE_ADDR is an error.

## Structure
- Package dmem_pkg holds:
  - size encodings: SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - the strobe-generation function;
  - the lane-align function for load data.
- Sub-module dmem_sram:
  - DEPTH_WORDS x 32 array with a 4-bit byte write enable;
  - synchronous write, read data registered at the same edge;
  - a write to a word and a read of that same word on one edge is not allowed; the responder never issues it, since one access happens per accept.
- dmem_responder contains the handshake FSM, error check, strobe/align logic and response registers.

## Test plan
- Word store/load:
  - store word 0xDEADBEEF to 0x8000_0010;
  - then load a word from 0x8000_0010 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, one cycle after accept.
- Byte/half lanes:
  - after the word store above, store byte 0x12 to 0x8000_0013 and store half 0x5678 to 0x8000_0010;
  - load word -> 0x12AD5678;
  - load byte from 0x8000_0013 -> 0x00000012;
  - load half from 0x8000_0012 -> 0x000012AD.
- Errors:
  - load half from 0x8000_0011 -> rsp_err = 1, rdata = 0;
  - store word to 0x8000_4000 (DEPTH_WORDS = 4096) -> rsp_err = 1, and a reload of word 0 shows it unchanged;
  - size = 3 -> rsp_err = 1.
- Backpressure:
  - hold rsp_ready = 0 for 5 cycles with req_valid = 1 -> req_ready = 0 and rsp_* stable throughout;
  - release -> one response per cycle, in order, with none lost or duplicated.
- Back-to-back: alternate store/load to the same word every cycle with rsp_ready = 1 -> each load returns the preceding store's value, at 1 request/cycle.
- Reset mid-operation:
  - assert rst while FULL with a store presented -> rsp_valid = 0 after the edge;
  - the store's target word retains its old value on reload.
